// File: rtl/demux_1x2_32bit_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
// Contents:
//   DEMUX_N, DEMUX_CNT_W      default data width and transfer counter width
//   DEMUX_SEL_Y0/Y1          destination select encodings
//   DEMUX_ST_EMPTY/FULL      holding-register state encodings
//   demux_state_t            state enum built on those encodings
//   demux_sel_ready()        ready of the output addressed by a select value
package demux_1x2_32bit_pkg;

    localparam int unsigned DEMUX_N     = 32;
    localparam int unsigned DEMUX_CNT_W = 16;

    localparam logic DEMUX_SEL_Y0 = 1'b0;
    localparam logic DEMUX_SEL_Y1 = 1'b1;

    localparam logic DEMUX_ST_EMPTY = 1'b0;
    localparam logic DEMUX_ST_FULL  = 1'b1;

    typedef enum logic {
        ST_EMPTY = DEMUX_ST_EMPTY,
        ST_FULL  = DEMUX_ST_FULL
    } demux_state_t;

    // Ready of the consumer that a given select value steers to.
    function automatic logic demux_sel_ready(
        input logic sel,
        input logic ready0,
        input logic ready1
    );
        return (sel == DEMUX_SEL_Y1) ? ready1 : ready0;
    endfunction

endpackage

// File: rtl/demux_1x2_32bit_hold_reg.sv
// demux_hold_reg: single-entry holding register for one stream beat.
// Stores n-bit data, the destination select and a valid flag.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   load       capture d/sel_d and set valid (takes priority over clear)
//   clear      drop the held beat (valid, data and select return to 0)
//   d, sel_d   incoming beat data and destination
//   q, sel_q   held beat data and destination
//   valid      a beat is held
module demux_hold_reg
    import demux_1x2_32bit_pkg::*;
#(
    parameter int unsigned n = DEMUX_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [n-1:0] d,
    input  logic         sel_d,
    output logic [n-1:0] q,
    output logic         sel_q,
    output logic         valid
);

    // A simultaneous load and clear is a take plus a new accept: the new beat wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            sel_q <= DEMUX_SEL_Y0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            sel_q <= sel_d;
            valid <= 1'b1;
        end else if (clear) begin
            q     <= '0;
            sel_q <= DEMUX_SEL_Y0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1x2_32bit.sv
// demux_1x2_32bit: registered 1-to-2 valid/ready stream demultiplexer.
// One producer stream is steered to y0 or y1 according to in_sel, which is
// sampled together with the beat. A single holding register gives one cycle
// of latency and full throughput while the addressed consumer keeps up.
// Optional feature macro: DEMUX_STATS_EN adds per-output delivered-beat
// counters cnt0/cnt1 (wrapping, cleared only by rst).
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready is 0 while rst is high
//   in_data, in_sel      input beat and destination (0 -> y0, 1 -> y1)
//   y0_valid/y0_ready    output 0 handshake, y0_data held beat or 0
//   y1_valid/y1_ready    output 1 handshake, y1_data held beat or 0
//   cnt0, cnt1           beats delivered on y0 / y1 (DEMUX_STATS_EN only)
module demux_1x2_32bit
    import demux_1x2_32bit_pkg::*;
#(
    parameter int unsigned n = DEMUX_N
`ifdef DEMUX_STATS_EN
    ,
    parameter int unsigned CNT_W = DEMUX_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     in_data,
    input  logic             in_sel,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [n-1:0]     y0_data,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [n-1:0]     y1_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic         held_valid;
    logic         held_sel;
    logic [n-1:0] held_data;
    logic         held_ready;
    logic         take;
    logic         accept;
    logic         load;
    logic         clear;
    demux_state_t state;

    // The holding register's valid flag is the EMPTY/FULL state bit.
    demux_hold_reg #(
        .n (n)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .clear (clear),
        .d     (in_data),
        .sel_d (in_sel),
        .q     (held_data),
        .sel_q (held_sel),
        .valid (held_valid)
    );

    assign state = demux_state_t'(held_valid);

    // Handshake and state transitions; the non-addressed ready never matters.
    always_comb begin
        held_ready = 1'b0;
        take       = 1'b0;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;

        held_ready = demux_sel_ready(held_sel, y0_ready, y1_ready);

        case (state)
            ST_EMPTY: begin
                in_ready = ~rst;
            end
            ST_FULL: begin
                take     = held_ready;
                // Space frees up in the same cycle the held beat leaves.
                in_ready = ~rst & held_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase

        accept = in_valid & in_ready;
        load   = accept;
        clear  = take & ~accept;
    end

    // Output steering: only the addressed output shows the held beat.
    always_comb begin
        y0_valid = 1'b0;
        y1_valid = 1'b0;
        y0_data  = '0;
        y1_data  = '0;

        if (state == ST_FULL) begin
            if (held_sel == DEMUX_SEL_Y1) begin
                y1_valid = 1'b1;
                y1_data  = held_data;
            end else begin
                y0_valid = 1'b1;
                y0_data  = held_data;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic take0;
    logic take1;

    assign take0 = y0_valid & y0_ready;
    assign take1 = y1_valid & y1_ready;

    // Delivered-beat counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (take0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (take1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule
